// File: rtl/wbr_out_mbist.sv
// Output-side IEEE 1500 wrapper boundary register for the MBIST core results.
// Optional build macro: WBR_SAFE_STATE_EN adds safe_outputs forcing of the test-path outputs.
module wbr_out_mbist #(
  parameter  int DATA_W = 8,
  localparam int L      = DATA_W + 2,
  localparam int CNT_W  = $clog2(L)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wse_outputs,
  input  logic              capture_outputs,
  input  logic              update_outputs,
  input  logic              hold_outputs,
`ifdef WBR_SAFE_STATE_EN
  input  logic              safe_outputs,
`endif
  input  logic              WPSI3,
  output logic              WPSO3,
  input  logic              CoreOUT_MBISTDONE,
  input  logic              CoreOUT_MBISTFAIL,
  input  logic [DATA_W-1:0] CoreOUT_DOUT,
  output logic              MBISTDONE,
  output logic              MBISTFAIL,
  output logic [DATA_W-1:0] DOUT,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  // Bit 0 is DOUT[0] (nearest WPSI3); bit L-1 is DONE (drives WPSO3).
  logic [L-1:0] sh;
  logic [L-1:0] up;

  always_ff @(posedge CLK) begin
    if (reset) begin
      sh         <= '0;
      up         <= '0;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wse_outputs) begin
        sh <= {sh[L-2:0], WPSI3};
        if (shift_cnt == LAST) begin
          shift_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          shift_cnt <= shift_cnt + CNT_W'(1);
        end
      end else if (capture_outputs) begin
        sh        <= {CoreOUT_MBISTDONE, CoreOUT_MBISTFAIL, CoreOUT_DOUT};
        shift_cnt <= '0;
      end
      if (update_outputs) up <= sh;
    end
  end

  assign WPSO3 = sh[L-1];

  always_comb begin
    MBISTDONE = CoreOUT_MBISTDONE;
    MBISTFAIL = CoreOUT_MBISTFAIL;
    DOUT      = CoreOUT_DOUT;
    if (hold_outputs) begin
      MBISTDONE = up[L-1];
      MBISTFAIL = up[L-2];
      DOUT      = up[DATA_W-1:0];
`ifdef WBR_SAFE_STATE_EN
      if (safe_outputs) begin
        MBISTDONE = 1'b0;
        MBISTFAIL = 1'b0;
        DOUT      = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_wbr_out_mbist.sv
// Directed self-checking bench for wbr_out_mbist (DATA_W=8, L=10).
module tb_wbr_out_mbist;

  logic       clk = 1'b0;
  logic       reset, wse, cap, upd, hold, wpsi, wpso;
  logic       core_done, core_fail, done_o, fail_o, fdone;
  logic [7:0] core_dout, dout_o;
  logic [3:0] cnt;
`ifdef WBR_SAFE_STATE_EN
  logic       safe;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  wbr_out_mbist #(.DATA_W(8)) dut (
    .CLK               (clk),
    .reset             (reset),
    .wse_outputs       (wse),
    .capture_outputs   (cap),
    .update_outputs    (upd),
    .hold_outputs      (hold),
`ifdef WBR_SAFE_STATE_EN
    .safe_outputs      (safe),
`endif
    .WPSI3             (wpsi),
    .WPSO3             (wpso),
    .CoreOUT_MBISTDONE (core_done),
    .CoreOUT_MBISTFAIL (core_fail),
    .CoreOUT_DOUT      (core_dout),
    .MBISTDONE         (done_o),
    .MBISTFAIL         (fail_o),
    .DOUT              (dout_o),
    .shift_cnt         (cnt),
    .frame_done        (fdone)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic d, input logic f, input logic [7:0] v);
    check({tag, "_done"}, 32'(done_o), 32'(d));
    check({tag, "_fail"}, 32'(fail_o), 32'(f));
    check({tag, "_dout"}, 32'(dout_o), 32'(v));
  endtask

  logic [9:0] exp_unload;
  logic [9:0] load_vec;

  initial begin
    reset = 1'b1; wse = 1'b0; cap = 1'b0; upd = 1'b0; hold = 1'b0; wpsi = 1'b0;
    core_done = 1'b0; core_fail = 1'b0; core_dout = 8'h00;
`ifdef WBR_SAFE_STATE_EN
    safe = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;

    // Fill chain and update stage with ones, then reset mid-shift
    wse = 1'b1; wpsi = 1'b1; upd = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; wse = 1'b0; upd = 1'b0; wpsi = 1'b0; hold = 1'b1;
    tick();
    check("rst_wpso", 32'(wpso), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_fdone", 32'(fdone), 32'd0);
    check_outs("rst_up", 1'b0, 1'b0, 8'h00);
    hold = 1'b0;

    // Capture 1/0/A5 and unload
    core_done = 1'b1; core_fail = 1'b0; core_dout = 8'hA5;
    exp_unload = 10'b10_1010_0101;
    cap = 1'b1;
    tick();
    cap = 1'b0;
    check("cap_wpso0", 32'(wpso), 32'(exp_unload[9]));
    check("cap_cnt", 32'(cnt), 32'd0);
    wse = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 9) check($sformatf("unload_wpso%0d", k), 32'(wpso), 32'(exp_unload[9-k]));
      check($sformatf("unload_fdone%0d", k), 32'(fdone), 32'(k == 10));
      check($sformatf("unload_cnt%0d", k), 32'(cnt), 32'(k % 10));
    end
    wse = 1'b0;
    tick();
    check("unload_fdone_after", 32'(fdone), 32'd0);

    // Shift in DONE=0 FAIL=1 DOUT=3C, update, observe
    load_vec = 10'b01_0011_1100;
    wse = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wpsi = load_vec[9-i];
      tick();
    end
    wse = 1'b0; wpsi = 1'b0;
    upd = 1'b1;
    tick();
    upd = 1'b0; hold = 1'b1;
    #1;
    check_outs("load_hold", 1'b0, 1'b1, 8'h3C);
    core_done = 1'b1; core_fail = 1'b0; core_dout = 8'hC3;
    hold = 1'b0;
    #1;
    check_outs("load_func", 1'b1, 1'b0, 8'hC3);

    // Shift beats capture
    core_done = 1'b0; core_fail = 1'b0; core_dout = 8'h00;
    wse = 1'b1; cap = 1'b1; wpsi = 1'b1;
    tick();
    cap = 1'b0;
    check("simul_wpso", 32'(wpso), 32'd1);
    check("simul_cnt", 32'(cnt), 32'd1);

    // Update during shift takes pre-shift contents (1 / 0 / 79)
    wpsi = 1'b0; upd = 1'b1;
    tick();
    upd = 1'b0; wse = 1'b0; hold = 1'b1;
    #1;
    check_outs("upd_shift", 1'b1, 1'b0, 8'h79);
    check("upd_shift_cnt", 32'(cnt), 32'd2);
    hold = 1'b0;

    // Wrap: capture zeros then 25 shifts of ones
    cap = 1'b1;
    tick();
    cap = 1'b0;
    check("wrap_cnt0", 32'(cnt), 32'd0);
    wse = 1'b1; wpsi = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      check($sformatf("wrap_fdone%0d", k), 32'(fdone), 32'(k == 10 || k == 20));
      check($sformatf("wrap_wpso%0d", k), 32'(wpso), 32'(k >= 10));
    end
    wse = 1'b0;
    check("wrap_cnt_end", 32'(cnt), 32'd5);

`ifdef WBR_SAFE_STATE_EN
    upd = 1'b1;
    tick();
    upd = 1'b0; hold = 1'b1; safe = 1'b1;
    #1;
    check_outs("safe_on", 1'b0, 1'b0, 8'h00);
    safe = 1'b0;
    #1;
    check_outs("safe_off", 1'b1, 1'b1, 8'hFF);
    hold = 1'b0; safe = 1'b1;
    #1;
    check_outs("safe_func", 1'b0, 1'b0, 8'h00);
    core_done = 1'b1; core_dout = 8'h42;
    #1;
    check_outs("safe_func2", 1'b1, 1'b0, 8'h42);
    safe = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
